// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares the UART TX port between a buffered ADS frame stream and a single register-response slot
module uart_tx_scheduler #(
    parameter int          ADS_FIFO_DEPTH = 4,
    parameter logic [7:0]  HDR_ADS        = 8'hAA,
    parameter logic [7:0]  HDR_ADS_REG    = 8'h61,
    parameter logic [7:0]  HDR_MPR_REG    = 8'h6D
) (
    input  logic        i_CLK,
    input  logic        i_RSTN,
    input  logic [55:0] i_ADS_DATA,
    input  logic        i_ADS_VALID,
    input  logic        i_STREAM_EN,
    input  logic [23:0] i_REG_DATA,
    input  logic        i_REG_VALID,
    output logic        o_REG_READY,
    output logic [55:0] o_UART_DATA_TX,
    output logic        o_UART_DATA_TX_VALID,
    input  logic        i_UART_DATA_TX_READY,
    output logic [3:0]  o_ADS_LEVEL,
    output logic [7:0]  o_ADS_DROP_CNT,
    output logic        o_HDR_ERR,
    output logic        o_BUSY
);
    localparam int         AW    = $clog2(ADS_FIFO_DEPTH);
    localparam logic [3:0] DEPTH = 4'(ADS_FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_OFFER, ST_WAIT} state_t;

    state_t        state;
    logic [55:0]   mem [ADS_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    level;
    logic [23:0]   reg_buf;
    logic          reg_full, r_ready_q;
    logic          ads_take, ads_bad, ads_pop, ads_wr, ads_drop, reg_take, reg_ok, reg_load;

    assign ads_take    = i_ADS_VALID && i_STREAM_EN && i_ADS_DATA[55:48] == HDR_ADS;
    assign ads_bad     = i_ADS_VALID && i_STREAM_EN && i_ADS_DATA[55:48] != HDR_ADS;
    assign reg_load    = state == ST_IDLE && reg_full;
    assign ads_pop     = state == ST_IDLE && !reg_full && i_STREAM_EN && level != 4'd0;
    assign ads_wr      = ads_take && (level < DEPTH || ads_pop);
    assign ads_drop    = ads_take && !ads_wr;
    assign reg_take    = i_REG_VALID && !reg_full;
    assign reg_ok      = i_REG_DATA[23:16] == HDR_ADS_REG || i_REG_DATA[23:16] == HDR_MPR_REG;
    assign o_REG_READY = !reg_full;
    assign o_ADS_LEVEL = level;
    assign o_BUSY      = state != ST_IDLE;

    // Frame storage; contents need no reset because level gates every read
    always_ff @(posedge i_CLK) begin
        if (ads_wr) mem[wr_ptr] <= i_ADS_DATA;
    end

    // FIFO pointers and occupancy, flushed whenever streaming is disabled; saturating drop counter
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= 4'd0;
            o_ADS_DROP_CNT <= 8'd0;
        end else begin
            if (!i_STREAM_EN) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= 4'd0;
            end else begin
                if (ads_wr) wr_ptr <= wr_ptr + 1'b1;
                if (ads_pop) rd_ptr <= rd_ptr + 1'b1;
                level <= level + 4'(ads_wr) - 4'(ads_pop);
            end
            if (ads_drop && o_ADS_DROP_CNT != 8'hFF) o_ADS_DROP_CNT <= o_ADS_DROP_CNT + 8'd1;
        end
    end

    // Single-entry register-response buffer; freed the cycle the FSM loads it
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            reg_full <= 1'b0;
            reg_buf  <= 24'd0;
        end else if (reg_load) begin
            reg_full <= 1'b0;
        end else if (reg_take && reg_ok) begin
            reg_full <= 1'b1;
            reg_buf  <= i_REG_DATA;
        end
    end

    // Header-error pulse and the delayed READY used to detect the controller's accept edge
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            o_HDR_ERR <= 1'b0;
            r_ready_q <= 1'b0;
        end else begin
            o_HDR_ERR <= ads_bad || (reg_take && !reg_ok);
            r_ready_q <= i_UART_DATA_TX_READY;
        end
    end

    // Offer/acknowledge FSM: a READY high-to-low transition while offering is the accept
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state                <= ST_IDLE;
            o_UART_DATA_TX       <= 56'd0;
            o_UART_DATA_TX_VALID <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (reg_load) begin
                        o_UART_DATA_TX       <= {reg_buf, 32'd0};
                        o_UART_DATA_TX_VALID <= 1'b1;
                        state                <= ST_OFFER;
                    end else if (ads_pop) begin
                        o_UART_DATA_TX       <= mem[rd_ptr];
                        o_UART_DATA_TX_VALID <= 1'b1;
                        state                <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (r_ready_q && !i_UART_DATA_TX_READY) begin
                        o_UART_DATA_TX       <= 56'd0;
                        o_UART_DATA_TX_VALID <= 1'b0;
                        state                <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_UART_DATA_TX_READY) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard-driven bench for the UART TX scheduler
module tb_uart_tx_scheduler;
    logic        clk = 1'b0;
    logic        rstn;
    logic [55:0] ads_data;
    logic        ads_valid;
    logic        stream_en;
    logic [23:0] reg_data;
    logic        reg_valid;
    logic        reg_ready;
    logic [55:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  level;
    logic [7:0]  drop_cnt;
    logic        hdr_err;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    logic [55:0] exp_q[$];
    bit          auto_ctrl = 1'b0;
    bit          cons_busy = 1'b0;

    uart_tx_scheduler dut (
        .i_CLK(clk), .i_RSTN(rstn),
        .i_ADS_DATA(ads_data), .i_ADS_VALID(ads_valid), .i_STREAM_EN(stream_en),
        .i_REG_DATA(reg_data), .i_REG_VALID(reg_valid), .o_REG_READY(reg_ready),
        .o_UART_DATA_TX(tx_data), .o_UART_DATA_TX_VALID(tx_valid),
        .i_UART_DATA_TX_READY(tx_ready),
        .o_ADS_LEVEL(level), .o_ADS_DROP_CNT(drop_cnt), .o_HDR_ERR(hdr_err), .o_BUSY(busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Controller model: accepts an offered word, drops READY for two cycles, checks the ack latency
    initial begin
        logic [55:0] w;
        forever begin
            @(negedge clk);
            if (auto_ctrl && tx_ready && tx_valid) begin
                cons_busy = 1'b1;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL cons_unexpected: got %h expected no word", tx_data);
                end else begin
                    w = exp_q.pop_front();
                    if (tx_data !== w) begin
                        failures++;
                        $display("FAIL cons_data: got %h expected %h", tx_data, w);
                    end
                end
                @(negedge clk);
                tx_ready = 1'b0;
                @(negedge clk);
                checks++;
                if (tx_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL cons_ack: got valid=%b expected 0", tx_valid);
                end
                @(negedge clk);
                tx_ready = 1'b1;
                cons_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_ads(input logic [55:0] d);
        ads_data = d;
        ads_valid = 1'b1;
        @(negedge clk);
        ads_valid = 1'b0;
    endtask

    task automatic push_reg(input logic [23:0] d);
        reg_data = d;
        reg_valid = 1'b1;
        @(negedge clk);
        reg_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        auto_ctrl = 1'b1;
        while ((exp_q.size() != 0 || cons_busy || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        auto_ctrl = 1'b0;
        ok = n < 400;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ads_data = '0; ads_valid = 1'b0; stream_en = 1'b1;
        reg_data = '0; reg_valid = 1'b0; tx_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 56'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_tx: got valid=%b data=%h busy=%b expected 0 0 0", tx_valid, tx_data, busy);
        end
        checks++;
        if (reg_ready !== 1'b1 || level !== 4'd0 || drop_cnt !== 8'd0 || hdr_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got rr=%b lvl=%0d drop=%0d herr=%b expected 1 0 0 0", reg_ready, level, drop_cnt, hdr_err);
        end
        rstn = 1'b1;
        repeat (2) tick();
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || reg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: got valid=%b busy=%b rr=%b expected 0 0 1", tx_valid, busy, reg_ready);
        end
    endtask

    task automatic test_single_ads();
        logic [55:0] f = 56'hAA0102030405_06;
        tx_ready = 1'b1;
        exp_q.push_back(f);
        push_ads(f);
        checks++;
        if (level !== 4'd1 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_push: got lvl=%0d valid=%b expected 1 0", level, tx_valid);
        end
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp_q[0] || level !== 4'd0) begin
            failures++;
            $display("FAIL single_offer: got valid=%b data=%h lvl=%0d expected 1 %h 0", tx_valid, tx_data, level, exp_q[0]);
        end
        tx_ready = 1'b0;
        tick();
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 56'd0) begin
            failures++;
            $display("FAIL single_ack: got valid=%b data=%h expected 0 0", tx_valid, tx_data);
        end
        exp_q.delete(0);
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL single_wait: got busy=%b expected 1", busy);
        end
        tx_ready = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got busy=%b valid=%b expected 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_reg_priority();
        logic [55:0] a1 = 56'hAA_0000000000A1;
        logic [55:0] rw = {24'h61105A, 32'd0};
        bit ok;
        tx_ready = 1'b0;
        exp_q.push_back(a1);
        push_ads(a1);
        tick();
        exp_q.push_back(rw);
        for (int i = 2; i <= 4; i++) begin
            exp_q.push_back({8'hAA, 48'(i) * 48'h111});
            push_ads({8'hAA, 48'(i) * 48'h111});
        end
        checks++;
        if (level !== 4'd3 || tx_valid !== 1'b1 || tx_data !== a1) begin
            failures++;
            $display("FAIL prio_setup: got lvl=%0d valid=%b data=%h expected 3 1 %h", level, tx_valid, tx_data, a1);
        end
        push_reg(24'h61105A);
        checks++;
        if (reg_ready !== 1'b0 || tx_data !== a1) begin
            failures++;
            $display("FAIL prio_held: got rr=%b data=%h expected 0 %h", reg_ready, tx_data, a1);
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL prio_ack: got valid=%b expected 0", tx_valid);
        end
        exp_q.delete(0);
        tx_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp_q[0] || reg_ready !== 1'b1 || level !== 4'd3) begin
            failures++;
            $display("FAIL prio_reg_first: got valid=%b data=%h rr=%b lvl=%0d expected 1 %h 1 3", tx_valid, tx_data, reg_ready, level, exp_q[0]);
        end
        drain(ok);
        checks++;
        if (!ok || level !== 4'd0) begin
            failures++;
            $display("FAIL prio_drain: got left=%0d lvl=%0d expected 0 0", exp_q.size(), level);
        end
    endtask

    task automatic test_overflow();
        logic [55:0] r2 = {24'h6D2233, 32'd0};
        logic [55:0] f7 = 56'hAA_000000000077;
        bit ok;
        tx_ready = 1'b0;
        exp_q.push_back(r2);
        push_reg(24'h6D2233);
        tick();
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) exp_q.push_back({8'hAA, 48'(i)});
            push_ads({8'hAA, 48'(i)});
        end
        exp_q.push_back(f7);
        checks++;
        if (level !== 4'd4 || drop_cnt !== 8'd2) begin
            failures++;
            $display("FAIL ovf_level: got lvl=%0d drop=%0d expected 4 2", level, drop_cnt);
        end
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== r2) begin
            failures++;
            $display("FAIL ovf_no_ack: got valid=%b data=%h expected 1 %h", tx_valid, tx_data, r2);
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();
        exp_q.delete(0);
        tx_ready = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || level !== 4'd4) begin
            failures++;
            $display("FAIL ovf_idle: got busy=%b lvl=%0d expected 0 4", busy, level);
        end
        push_ads(f7);
        checks++;
        if (level !== 4'd4 || drop_cnt !== 8'd2 || tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
            failures++;
            $display("FAIL ovf_full_pop: got lvl=%0d drop=%0d valid=%b data=%h expected 4 2 1 %h", level, drop_cnt, tx_valid, tx_data, exp_q[0]);
        end
        drain(ok);
        checks++;
        if (!ok || level !== 4'd0 || drop_cnt !== 8'd2) begin
            failures++;
            $display("FAIL ovf_drain: got left=%0d lvl=%0d drop=%0d expected 0 0 2", exp_q.size(), level, drop_cnt);
        end
    endtask

    task automatic test_rx_priority();
        logic [55:0] f = 56'hAA_CAFEBABE0001;
        tx_ready = 1'b1;
        exp_q.push_back(f);
        push_ads(f);
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
                failures++;
                $display("FAIL rx_hold%0d: got valid=%b data=%h expected 1 %h", i, tx_valid, tx_data, exp_q[0]);
            end
            tick();
        end
        tx_ready = 1'b0;
        tick();
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rx_ack: got valid=%b expected 0", tx_valid);
        end
        exp_q.delete(0);
        tick();
        tx_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rx_single: got valid=%b busy=%b expected 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_bad_header();
        push_ads(56'hBB_112233445566);
        checks++;
        if (hdr_err !== 1'b1 || level !== 4'd0) begin
            failures++;
            $display("FAIL bad_ads: got herr=%b lvl=%0d expected 1 0", hdr_err, level);
        end
        tick();
        checks++;
        if (hdr_err !== 1'b0) begin
            failures++;
            $display("FAIL bad_ads_pulse: got herr=%b expected 0", hdr_err);
        end
        push_reg(24'h520000);
        checks++;
        if (hdr_err !== 1'b1 || reg_ready !== 1'b1) begin
            failures++;
            $display("FAIL bad_reg: got herr=%b rr=%b expected 1 1", hdr_err, reg_ready);
        end
        tick();
        checks++;
        if (hdr_err !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || level !== 4'd0) begin
            failures++;
            $display("FAIL bad_after: got herr=%b valid=%b busy=%b lvl=%0d expected 0 0 0 0", hdr_err, tx_valid, busy, level);
        end
    endtask

    task automatic test_stream_flush();
        logic [55:0] a1 = 56'hAA_F00000000001;
        tx_ready = 1'b0;
        push_ads(a1);
        tick();
        for (int i = 2; i <= 4; i++) push_ads({8'hAA, 48'(i)});
        checks++;
        if (level !== 4'd3) begin
            failures++;
            $display("FAIL flush_setup: got lvl=%0d expected 3", level);
        end
        stream_en = 1'b0;
        tick();
        checks++;
        if (level !== 4'd0 || tx_valid !== 1'b1 || tx_data !== a1) begin
            failures++;
            $display("FAIL flush_level: got lvl=%0d valid=%b data=%h expected 0 1 %h", level, tx_valid, tx_data, a1);
        end
        push_ads(56'hAA_000000000005);
        checks++;
        if (level !== 4'd0 || drop_cnt !== 8'd2 || hdr_err !== 1'b0) begin
            failures++;
            $display("FAIL flush_ignore: got lvl=%0d drop=%0d herr=%b expected 0 2 0", level, drop_cnt, hdr_err);
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_complete: got valid=%b expected 0", tx_valid);
        end
        tx_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: got busy=%b valid=%b expected 0 0", busy, tx_valid);
        end
        stream_en = 1'b1;
    endtask

    task automatic test_async_reset();
        tx_ready = 1'b0;
        exp_q.push_back(56'hAA_00000000ABCD);
        push_ads(56'hAA_00000000ABCD);
        tick();
        push_ads(56'hAA_00000000ABCE);
        push_reg(24'h61AB01);
        checks++;
        if (tx_valid !== 1'b1 || level !== 4'd1 || reg_ready !== 1'b0 || drop_cnt !== 8'd2) begin
            failures++;
            $display("FAIL arst_setup: got valid=%b lvl=%0d rr=%b drop=%0d expected 1 1 0 2", tx_valid, level, reg_ready, drop_cnt);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 56'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL arst_tx: got valid=%b data=%h busy=%b expected 0 0 0", tx_valid, tx_data, busy);
        end
        checks++;
        if (level !== 4'd0 || drop_cnt !== 8'd0 || reg_ready !== 1'b1) begin
            failures++;
            $display("FAIL arst_state: got lvl=%0d drop=%0d rr=%b expected 0 0 1", level, drop_cnt, reg_ready);
        end
        exp_q.delete();
        tick();
        rstn = 1'b1;
        tx_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_ads();
        test_reg_priority();
        test_overflow();
        test_rx_priority();
        test_bad_header();
        test_stream_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
